// File: rtl/strand_issue_unit_if.sv
// Issue-unit bus: per-strand fetch/control inputs and the granted issue slot.
interface strand_issue_unit_if;
    logic [3:0]   strand_enable_i;
    logic [127:0] instruction_i;
    logic [3:0]   instruction_valid_i;
    logic [127:0] pc_i;
    logic [3:0]   flush_i;
    logic [3:0]   suspend_strand_i;
    logic [3:0]   resume_strand_i;
    logic [127:0] rollback_strided_offset_i;
    logic [15:0]  rollback_reg_lane_i;
    logic [3:0]   next_instruction_o;
    logic [3:0]   grant_o;
    logic         issue_valid_o;
    logic [1:0]   issue_strand_o;
    logic [31:0]  pc_o;
    logic [31:0]  instruction_o;
    logic [3:0]   reg_lane_select_o;
    logic [31:0]  strided_offset_o;

    modport slave (
        input  strand_enable_i, instruction_i, instruction_valid_i, pc_i,
               flush_i, suspend_strand_i, resume_strand_i,
               rollback_strided_offset_i, rollback_reg_lane_i,
        output next_instruction_o, grant_o, issue_valid_o, issue_strand_o,
               pc_o, instruction_o, reg_lane_select_o, strided_offset_o
    );

    modport master (
        output strand_enable_i, instruction_i, instruction_valid_i, pc_i,
               flush_i, suspend_strand_i, resume_strand_i,
               rollback_strided_offset_i, rollback_reg_lane_i,
        input  next_instruction_o, grant_o, issue_valid_o, issue_strand_o,
               pc_o, instruction_o, reg_lane_select_o, strided_offset_o
    );
endinterface

// File: rtl/strand_issue_unit.sv
// Barrel-core issue control: one state machine per strand plus a
// round-robin arbiter that picks at most one requesting strand per cycle.

// Per-strand sequencer: vector lane walk, load-use wait, suspend/flush rollback.
module strand_issue_strand #(
    parameter int RAW_WAIT_CYCLES = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable_i,
    input  logic         valid_i,
    input  logic [31:15] instr_i,
    input  logic         flush_i,
    input  logic         suspend_i,
    input  logic         resume_i,
    input  logic [3:0]   rb_lane_i,
    input  logic [31:0]  rb_offset_i,
    input  logic         grant_i,
    output logic         request_o,
    output logic         next_instruction_o,
    output logic [3:0]   lane_o,
    output logic [31:0]  offset_o
);
    localparam int CNT_W = (RAW_WAIT_CYCLES < 2) ? 1 : $clog2(RAW_WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] RAW_LOAD = CNT_W'(RAW_WAIT_CYCLES);

    typedef enum logic [1:0] {S_READY, S_VECTOR, S_RAW_WAIT, S_SUSPENDED} state_e;

    state_e           state_q, state_d;
    logic [3:0]       lane_q, lane_d;
    logic [31:0]      offset_q, offset_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        is_mem, is_load, is_multi;
    logic [31:0] stride;

    assign is_mem   = (instr_i[31:30] == 2'b10);
    assign is_load  = is_mem && instr_i[29];
    assign is_multi = is_mem && (instr_i[28:25] inside
                      {4'b0111, 4'b1000, 4'b1001, 4'b1101, 4'b1110, 4'b1111});
    assign stride   = {{22{instr_i[24]}}, instr_i[24:15]};

    // Reset also drops the request so the issue slot reads empty while held.
    assign request_o = !rst && valid_i && enable_i && !flush_i &&
                       (state_q == S_READY || state_q == S_VECTOR);
    // Fetch advances on single-cycle issue, or on the last lane of a vector op.
    assign next_instruction_o = grant_i && (!is_multi || lane_q == 4'd0);
    assign lane_o   = lane_q;
    assign offset_o = offset_q;

    // Next state: flush > suspend > resume > grant; RAW counter runs on its own.
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        offset_d = offset_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            state_d  = S_READY;
            lane_d   = rb_lane_i;
            offset_d = rb_offset_i;
            cnt_d    = '0;
        end else if (suspend_i) begin
            state_d  = S_SUSPENDED;
            lane_d   = rb_lane_i;
            offset_d = rb_offset_i;
            cnt_d    = '0;
        end else if (resume_i && state_q == S_SUSPENDED) begin
            state_d = S_READY;
        end else begin
            if (state_q == S_RAW_WAIT) begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            if (grant_i) begin
                if (is_multi && lane_q != 4'd0) begin
                    state_d  = S_VECTOR;
                    lane_d   = lane_q - 4'd1;
                    offset_d = offset_q + stride;
                end else begin
                    // Single-cycle op or last vector lane: op is retired.
                    if (is_multi) begin
                        lane_d   = 4'd15;
                        offset_d = '0;
                    end
                    state_d = is_load ? S_RAW_WAIT : S_READY;
                    cnt_d   = is_load ? RAW_LOAD : '0;
                end
            end
        end
    end

    // Strand state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_READY;
            lane_q   <= 4'd15;
            offset_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module strand_issue_unit #(
    parameter int RAW_WAIT_CYCLES = 3
) (
    input  logic                clk,
    input  logic                reset,
    strand_issue_unit_if.slave  bus
);
    localparam int NUM_STRANDS = 4;

    logic [NUM_STRANDS-1:0]       req, grant, next_instr;
    logic [NUM_STRANDS-1:0][3:0]  lane;
    logic [NUM_STRANDS-1:0][31:0] offset, pc_a, instr_a, rb_off_a;
    logic [NUM_STRANDS-1:0][3:0]  rb_lane_a;
    logic [1:0] last_q, last_d, win, cand;
    logic       found;

    assign pc_a      = bus.pc_i;
    assign instr_a   = bus.instruction_i;
    assign rb_off_a  = bus.rollback_strided_offset_i;
    assign rb_lane_a = bus.rollback_reg_lane_i;

    for (genvar s = 0; s < NUM_STRANDS; s++) begin : g_strand
        strand_issue_strand #(.RAW_WAIT_CYCLES(RAW_WAIT_CYCLES)) u_strand (
            .clk                (clk),
            .rst                (reset),
            .enable_i           (bus.strand_enable_i[s]),
            .valid_i            (bus.instruction_valid_i[s]),
            .instr_i            (instr_a[s][31:15]),
            .flush_i            (bus.flush_i[s]),
            .suspend_i          (bus.suspend_strand_i[s]),
            .resume_i           (bus.resume_strand_i[s]),
            .rb_lane_i          (rb_lane_a[s]),
            .rb_offset_i        (rb_off_a[s]),
            .grant_i            (grant[s]),
            .request_o          (req[s]),
            .next_instruction_o (next_instr[s]),
            .lane_o             (lane[s]),
            .offset_o           (offset[s])
        );
    end

    // Round-robin pick: first requester after the last winner, wrapping.
    always_comb begin
        found = 1'b0;
        win   = last_q;
        cand  = last_q;
        grant = '0;
        for (int k = 1; k <= NUM_STRANDS; k++) begin
            cand = last_q + 2'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found) grant[win] = 1'b1;
        last_d = found ? win : last_q;
    end

    // Issue slot mux; all-zero when nothing is granted.
    always_comb begin
        bus.issue_strand_o    = '0;
        bus.pc_o              = '0;
        bus.instruction_o     = '0;
        bus.reg_lane_select_o = '0;
        bus.strided_offset_o  = '0;
        if (found) begin
            bus.issue_strand_o    = win;
            bus.pc_o              = pc_a[win];
            bus.instruction_o     = instr_a[win];
            bus.reg_lane_select_o = lane[win];
            bus.strided_offset_o  = offset[win];
        end
    end

    assign bus.grant_o            = grant;
    assign bus.issue_valid_o      = found;
    assign bus.next_instruction_o = next_instr;

    // Arbiter pointer: moves only on an actual issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 2'd3;
        else       last_q <= last_d;
    end
endmodule

// File: tb/tb_strand_issue_unit.sv
// Bench for strand_issue_unit: directed scenarios plus random traffic, all
// checked every cycle against a queue-free behavioural model of the strands.
module tb_strand_issue_unit;
    localparam int RAW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    strand_issue_unit_if bus();
    strand_issue_unit #(.RAW_WAIT_CYCLES(RAW)) dut (.clk(clk), .reset(rst), .bus(bus));

    logic [3:0]  en, vld, fl, su, rs;
    logic [31:0] instr[4], pc[4], rb_off[4];
    logic [3:0]  rb_lane[4];
    bit          auto_fetch;
    int          checks, failures;

    // Model: per strand, blocked-cycle count, suspended flag, lane and offset.
    int          m_lane[4], m_wait[4], m_last;
    logic [31:0] m_off[4];
    bit          m_susp[4];

    logic [3:0]  exp_grant, exp_next, exp_lane;
    bit          exp_valid;
    int          exp_win;
    logic [31:0] exp_pc, exp_instr, exp_off;

    logic [3:0]  act_grant, act_next, act_lane;
    logic [31:0] act_pc, act_off;

    function automatic bit f_multi(logic [31:0] i);
        return i[31:30] == 2'b10 && (i[28:25] inside {4'd7, 4'd8, 4'd9, 4'd13, 4'd14, 4'd15});
    endfunction
    function automatic bit f_load(logic [31:0] i);
        return i[31:30] == 2'b10 && i[29];
    endfunction
    function automatic logic [31:0] f_stride(logic [31:0] i);
        return 32'(signed'(i[24:15]));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[31:30] = 2'b00;
            1: begin r[31:30] = 2'b10; r[28:25] = 4'($urandom_range(0, 6)); end
            default: begin
                r[31:30] = 2'b10;
                case ($urandom_range(0, 5))
                    0: r[28:25] = 4'd7;  1: r[28:25] = 4'd8;  2: r[28:25] = 4'd9;
                    3: r[28:25] = 4'd13; 4: r[28:25] = 4'd14; default: r[28:25] = 4'd15;
                endcase
            end
        endcase
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_lane[s] = 15; m_off[s] = '0; m_wait[s] = 0; m_susp[s] = 0;
        end
        m_last = 3;
    endtask

    task automatic model_outputs();
        exp_grant = '0; exp_next = '0; exp_valid = 0; exp_win = 0;
        exp_pc = '0; exp_instr = '0; exp_lane = '0; exp_off = '0;
        if (!rst) begin
            for (int k = 1; k <= 4; k++) begin
                int s;
                s = (m_last + k) % 4;
                if (!exp_valid && vld[s] && en[s] && !fl[s] && !m_susp[s] && m_wait[s] == 0) begin
                    exp_valid = 1; exp_win = s;
                end
            end
        end
        if (exp_valid) begin
            exp_grant[exp_win] = 1'b1;
            exp_pc    = pc[exp_win];
            exp_instr = instr[exp_win];
            exp_lane  = 4'(m_lane[exp_win]);
            exp_off   = m_off[exp_win];
            exp_next[exp_win] = !f_multi(instr[exp_win]) || m_lane[exp_win] == 0;
        end
    endtask

    task automatic model_update();
        if (rst) begin model_reset(); return; end
        for (int s = 0; s < 4; s++) begin
            if (fl[s]) begin
                m_susp[s] = 0; m_wait[s] = 0; m_lane[s] = int'(rb_lane[s]); m_off[s] = rb_off[s];
            end else if (su[s]) begin
                m_susp[s] = 1; m_wait[s] = 0; m_lane[s] = int'(rb_lane[s]); m_off[s] = rb_off[s];
            end else if (rs[s] && m_susp[s]) begin
                m_susp[s] = 0;
            end else begin
                if (m_wait[s] > 0) m_wait[s]--;
                if (exp_valid && exp_win == s) begin
                    if (f_multi(instr[s]) && m_lane[s] > 0) begin
                        m_lane[s]--; m_off[s] += f_stride(instr[s]);
                    end else begin
                        if (f_multi(instr[s])) begin m_lane[s] = 15; m_off[s] = '0; end
                        if (f_load(instr[s])) m_wait[s] = RAW;
                    end
                end
            end
        end
        if (exp_valid) m_last = exp_win;
    endtask

    // One cycle: drive at negedge, compare just after, advance model at posedge.
    task automatic step();
        bus.strand_enable_i     = en;
        bus.instruction_valid_i = vld;
        bus.flush_i             = fl;
        bus.suspend_strand_i    = su;
        bus.resume_strand_i     = rs;
        for (int s = 0; s < 4; s++) begin
            bus.instruction_i[32*s +: 32]             = instr[s];
            bus.pc_i[32*s +: 32]                      = pc[s];
            bus.rollback_strided_offset_i[32*s +: 32] = rb_off[s];
            bus.rollback_reg_lane_i[4*s +: 4]         = rb_lane[s];
        end
        #1;
        model_outputs();
        act_grant = bus.grant_o; act_next = bus.next_instruction_o;
        act_lane = bus.reg_lane_select_o; act_pc = bus.pc_o; act_off = bus.strided_offset_o;
        chk("grant", bus.grant_o, exp_grant);
        chk("issue_valid", bus.issue_valid_o, exp_valid);
        chk("issue_strand", bus.issue_strand_o, exp_valid ? exp_win : 0);
        chk("pc", bus.pc_o, exp_pc);
        chk("instruction", bus.instruction_o, exp_instr);
        chk("lane", bus.reg_lane_select_o, exp_lane);
        chk("offset", bus.strided_offset_o, exp_off);
        chk("next_instruction", bus.next_instruction_o, exp_next);
        @(posedge clk);
        model_update();
        if (auto_fetch)
            for (int s = 0; s < 4; s++)
                if (exp_next[s]) begin instr[s] = rand_instr(); pc[s] += 32'd4; end
        @(negedge clk);
    endtask

    initial begin
        checks = 0; failures = 0; auto_fetch = 0;
        en = '0; vld = '0; fl = '0; su = '0; rs = '0;
        for (int s = 0; s < 4; s++) begin
            instr[s] = 32'h13; pc[s] = 32'h1000 * (s + 1); rb_off[s] = '0; rb_lane[s] = 4'd15;
        end
        model_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        en = 4'hF; vld = 4'hF;          // requests held during reset must not issue
        step();
        chk("reset_grant", act_grant, 0);
        rst = 1'b0;

        // Single non-memory instruction on strand 0
        en = 4'b0001; vld = 4'b0001; pc[0] = 32'h100;
        step();
        chk("t1_grant", act_grant, 4'b0001);
        chk("t1_next", act_next, 4'b0001);
        chk("t1_pc", act_pc, 32'h100);
        step();
        chk("t1_again", act_grant, 4'b0001);

        // Round-robin over all four, then over strands 0 and 2
        en = 4'hF; vld = 4'hF;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_rr4", act_grant, 32'(1) << ((i + 1) % 4));
        end
        en = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_rr2", act_grant, (i % 2 == 0) ? 32'd4 : 32'd1);
        end

        // Strided load, stride 4, on strand 1 alone
        en = 4'b0010; vld = 4'b0010; instr[1] = 32'hAE02_0000;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t3_grant", act_grant, 4'b0010);
            chk("t3_lane", act_lane, 15 - i);
            chk("t3_off", act_off, 4 * i);
            chk("t3_next", act_next, (i == 15) ? 4'b0010 : 4'b0000);
        end
        instr[1] = 32'h13;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_raw_block", act_grant, 0);
        end
        step();
        chk("t3_raw_release", act_grant, 4'b0010);

        // Suspend mid-vector store, resume from rollback lane 10 / offset 20
        instr[1] = 32'h8E02_0000;
        for (int i = 0; i < 6; i++) step();
        su = 4'b0010; rb_lane[1] = 4'd10; rb_off[1] = 32'd20;
        step();
        chk("t4_lane_at_suspend", act_lane, 9);
        su = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_suspended", act_grant, 0);
        end
        rs = 4'b0010;
        step();
        chk("t4_resume_cycle", act_grant, 0);
        rs = '0;
        step();
        chk("t4_resume_lane", act_lane, 10);
        chk("t4_resume_off", act_off, 20);
        for (int i = 0; i < 10; i++) step();
        chk("t4_final_lane", act_lane, 0);
        chk("t4_final_off", act_off, 60);
        chk("t4_final_next", act_next, 4'b0010);

        // Flush and suspend together on strand 2
        en = 4'b0100; vld = 4'b0100; instr[2] = 32'hAE02_0000;
        for (int i = 0; i < 3; i++) step();
        fl = 4'b0100; su = 4'b0100; rb_lane[2] = 4'd5; rb_off[2] = 32'd100;
        step();
        chk("t5_flush_block", act_grant, 0);
        fl = '0; su = '0;
        step();
        chk("t5_grant", act_grant, 4'b0100);
        chk("t5_lane", act_lane, 5);
        chk("t5_off", act_off, 100);

        // Idle cycle keeps the pointer at strand 2
        vld = '0;
        step();
        chk("t6_idle_grant", act_grant, 0);
        chk("t6_idle_pc", act_pc, 0);
        en = 4'hF; vld = 4'hF;
        for (int s = 0; s < 4; s++) instr[s] = 32'h13;
        step();
        chk("t6_after_idle", act_grant, 4'b1000);

        // Reset in the middle of a vector op
        en = 4'b0010; vld = 4'b0010; instr[1] = 32'hAE02_0000;
        step(); step();
        rst = 1'b1;
        step();
        chk("t7_rst_grant", act_grant, 0);
        chk("t7_rst_off", act_off, 0);
        rst = 1'b0;
        en = 4'hF;
        step();
        chk("t7_post_grant", act_grant, 4'b0010);
        chk("t7_post_lane", act_lane, 15);

        // Random traffic
        auto_fetch = 1;
        for (int s = 0; s < 4; s++) instr[s] = rand_instr();
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            for (int s = 0; s < 4; s++) begin
                vld[s] = ($urandom_range(0, 99) < 85);
                fl[s]  = ($urandom_range(0, 99) < 2);
                su[s]  = ($urandom_range(0, 99) < 3);
                rs[s]  = ($urandom_range(0, 99) < 25);
                rb_lane[s] = 4'($urandom);
                rb_off[s]  = $urandom;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
